// File: rtl/mod_inv_if.sv
// Request/response handshake bundle for mod_inv: operand side (in_*) and result side (out_*).
interface mod_inv_if #(
    parameter int FIELD_WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [FIELD_WIDTH-1:0] a;
    logic [FIELD_WIDTH-1:0] s;
    logic                   out_valid;
    logic                   out_ready;
    logic [FIELD_WIDTH-1:0] r;
    logic                   err;

    modport master (
        output in_valid, a, s, out_ready,
        input  in_ready, out_valid, r, err
    );

    modport slave (
        input  in_valid, a, s, out_ready,
        output in_ready, out_valid, r, err
    );
endinterface

// File: rtl/mod_inv.sv
// Iterative modular inverse r = a^-1 mod s via binary extended Euclid, one step per clock.
// Optional macro MOD_INV_CYCLE_CNT_EN adds a 'cycles' port counting clocks spent in RUN.
module mod_inv #(
    parameter int FIELD_WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    mod_inv_if.slave bus
`ifdef MOD_INV_CYCLE_CNT_EN
    ,
    output logic [$clog2(4*FIELD_WIDTH+3)-1:0] cycles
`endif
);
    localparam int W = FIELD_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   s_q, s_nx;
    logic [W-1:0]   u_q, u_nx;
    logic [W-1:0]   v_q, v_nx;
    logic [W-1:0]   x1_q, x1_nx;
    logic [W-1:0]   x2_q, x2_nx;
    logic [W-1:0]   r_q, r_nx;
    logic           err_q, err_nx;

    // Sums and differences carry one extra bit so the halving shift sees the true value.
    logic [W:0]     x1_plus_s, x2_plus_s;
    logic [W:0]     x1_minus_x2, x2_minus_x1;
    logic           bad_operand;

    always_comb begin
        x1_plus_s   = {1'b0, x1_q} + {1'b0, s_q};
        x2_plus_s   = {1'b0, x2_q} + {1'b0, s_q};
        x1_minus_x2 = (x1_q >= x2_q) ? ({1'b0, x1_q} - {1'b0, x2_q})
                                     : ({1'b0, x1_q} + {1'b0, s_q} - {1'b0, x2_q});
        x2_minus_x1 = (x2_q >= x1_q) ? ({1'b0, x2_q} - {1'b0, x1_q})
                                     : ({1'b0, x2_q} + {1'b0, s_q} - {1'b0, x1_q});
        bad_operand = (bus.a == '0) || (bus.a >= bus.s) || !bus.s[0] || (bus.s < W'(3));
    end

    always_comb begin
        state_nx = state;
        s_nx     = s_q;
        u_nx     = u_q;
        v_nx     = v_q;
        x1_nx    = x1_q;
        x2_nx    = x2_q;
        r_nx     = r_q;
        err_nx   = err_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    s_nx  = bus.s;
                    u_nx  = bus.a;
                    v_nx  = bus.s;
                    x1_nx = W'(1);
                    x2_nx = '0;
                    if (bad_operand) begin
                        r_nx     = '0;
                        err_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (u_q == W'(1)) begin
                    r_nx     = x1_q;
                    err_nx   = 1'b0;
                    state_nx = DONE;
                end else if (v_q == W'(1)) begin
                    r_nx     = x2_q;
                    err_nx   = 1'b0;
                    state_nx = DONE;
                end else if (u_q == '0 || v_q == '0) begin
                    r_nx     = '0;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else if (!u_q[0]) begin
                    u_nx  = u_q >> 1;
                    x1_nx = x1_q[0] ? x1_plus_s[W:1] : (x1_q >> 1);
                end else if (!v_q[0]) begin
                    v_nx  = v_q >> 1;
                    x2_nx = x2_q[0] ? x2_plus_s[W:1] : (x2_q >> 1);
                end else if (u_q >= v_q) begin
                    u_nx  = u_q - v_q;
                    x1_nx = x1_minus_x2[W-1:0];
                end else begin
                    v_nx  = v_q - u_q;
                    x2_nx = x2_minus_x1[W-1:0];
                end
            end
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s_q   <= '0;
            u_q   <= '0;
            v_q   <= '0;
            x1_q  <= '0;
            x2_q  <= '0;
            r_q   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            s_q   <= s_nx;
            u_q   <= u_nx;
            v_q   <= v_nx;
            x1_q  <= x1_nx;
            x2_q  <= x2_nx;
            r_q   <= r_nx;
            err_q <= err_nx;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.r         = r_q;
    assign bus.err       = err_q;

`ifdef MOD_INV_CYCLE_CNT_EN
    logic [$clog2(4*FIELD_WIDTH+3)-1:0] cyc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            cyc_q <= '0;
        end else if (state == RUN) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign cycles = cyc_q;
`endif
endmodule

// File: tb/tb_mod_inv.sv
// Scoreboard bench for mod_inv: directed vectors, backpressure, mid-run reset, random inverse property.
module tb_mod_inv;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic         err;
        bit           prop;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mod_inv_if #(.FIELD_WIDTH(W)) bus ();

`ifdef MOD_INV_CYCLE_CNT_EN
    logic [$clog2(4*W+3)-1:0] cycles;
    mod_inv #(.FIELD_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus), .cycles(cycles));
`else
    mod_inv #(.FIELD_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    task automatic chk(input string name, input longint act, input longint expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compares every accepted result against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_output: got r=%0d err=%0d expected none", bus.r, bus.err);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.prop) begin
                    chk("rand_err", longint'(bus.err), 0);
                    chk("rand_a_times_r_mod_s",
                        (longint'(mon_e.a) * longint'(bus.r)) % longint'(mon_e.s), 1);
                end else begin
                    chk("r", longint'(bus.r), longint'(mon_e.r));
                    chk("err", longint'(bus.err), longint'(mon_e.err));
                end
            end
        end
    end

    // lat_mode: 0 no check, 1 exact, 2 upper bound. hold leaves the result pending in DONE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] s,
                         input logic [W-1:0] r, input logic err, input bit prop,
                         input int lat_mode, input int lat_exp, input bit hold);
        exp_t e;
        int   lat;
        @(posedge clk); #1;
        bus.a        = a;
        bus.s        = s;
        bus.in_valid = 1'b1;
        @(posedge clk);
        e.a = a; e.s = s; e.r = r; e.err = err; e.prop = prop;
        sb.push_back(e);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.s        = ~s;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) begin
            chk("timeout", 0, 1);
            reset = 1'b1;
            sb.delete();
            @(posedge clk); #1;
            reset = 1'b0;
        end else begin
            if (lat_mode == 1) chk("latency", lat, lat_exp);
            if (lat_mode == 2) chk("latency_max", longint'(lat <= lat_exp), 1);
            if (!hold) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        logic [W-1:0] r0;
        logic         e0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.s         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_r", longint'(bus.r), 0);
        chk("rst_err", longint'(bus.err), 0);
        reset = 1'b0;

        do_op(16'd3,     16'd17,    16'd6,     1'b0, 1'b0, 2, 66, 1'b0);
        do_op(16'd2,     16'd65521, 16'd32761, 1'b0, 1'b0, 2, 66, 1'b0);
        do_op(16'd65520, 16'd65521, 16'd65520, 1'b0, 1'b0, 2, 66, 1'b0);
        do_op(16'd1,     16'd65521, 16'd1,     1'b0, 1'b0, 1, 2,  1'b0);
        do_op(16'd3,     16'd65521, 16'd43681, 1'b0, 1'b0, 2, 66, 1'b0);
        do_op(16'd2,     16'd65535, 16'd32768, 1'b0, 1'b0, 2, 66, 1'b0);
        do_op(16'd2,     16'd3,     16'd2,     1'b0, 1'b0, 2, 66, 1'b0);

        do_op(16'd0,  16'd17, 16'd0, 1'b1, 1'b0, 1, 1, 1'b0);
        do_op(16'd17, 16'd17, 16'd0, 1'b1, 1'b0, 1, 1, 1'b0);
        do_op(16'd3,  16'd16, 16'd0, 1'b1, 1'b0, 1, 1, 1'b0);
        do_op(16'd0,  16'd1,  16'd0, 1'b1, 1'b0, 1, 1, 1'b0);
        do_op(16'd1,  16'd2,  16'd0, 1'b1, 1'b0, 1, 1, 1'b0);
        do_op(16'd3,  16'd3,  16'd0, 1'b1, 1'b0, 1, 1, 1'b0);

        do_op(16'd5, 16'd15, 16'd0,  1'b1, 1'b0, 2, 66, 1'b0);
        do_op(16'd7, 16'd15, 16'd13, 1'b0, 1'b0, 2, 66, 1'b0);
        do_op(16'd6, 16'd9,  16'd0,  1'b1, 1'b0, 2, 66, 1'b0);

        // Backpressure: result must hold and a competing request must be refused.
        bus.out_ready = 1'b0;
        do_op(16'd3, 16'd17, 16'd6, 1'b0, 1'b0, 0, 0, 1'b1);
        r0 = bus.r;
        e0 = bus.err;
        bus.a        = 16'd5;
        bus.s        = 16'd19;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_r_stable", longint'(bus.r), longint'(r0));
            chk("bp_err_stable", longint'(bus.err), longint'(e0));
            chk("bp_in_ready", longint'(bus.in_ready), 0);
            chk("bp_out_valid", longint'(bus.out_valid), 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", longint'(bus.out_valid), 0);
        chk("bp_release_in_ready", longint'(bus.in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_stray_op", longint'(bus.out_valid), 0);

        // Reset in the middle of a long run discards the operation.
        @(posedge clk); #1;
        bus.a        = 16'd12345;
        bus.s        = 16'd65521;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_run_busy", longint'(bus.in_ready), 0);
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        chk("abort_out_valid", longint'(bus.out_valid), 0);
        chk("abort_in_ready", longint'(bus.in_ready), 1);
        reset = 1'b0;
        do_op(16'd3, 16'd17, 16'd6, 1'b0, 1'b0, 2, 66, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom_range(1, 65520)), 16'd65521, 16'd0, 1'b0, 1'b1, 2, 66, 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", longint'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
